keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Synthesizable model of the 4x4 matrix keypad, i.e. the far end of the row-drive/column-sense interface.
- Senses the active-low row lines driven by the scanner.
- Pulls the matching column line low while an emulated key contact is closed.
- Driven by a command handshake (key code, hold time); generates pseudo-random contact bounce on press and release, so scanner, debouncer and ghost-rejection logic can be exercised in simulation and on hardware loopback.

Parameters:
- BOUNCE_CYCLES, 64, cycles of bounce on each press and each release; 0 = clean edges.
- HOLD_W, 16, width of the hold-time field.
- LFSR_SEED, 8'hA5, reset value of the bounce LFSR; must be non-zero.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  emulator idle, command accepted when cmd_valid && cmd_ready
- cmd_key  in  4  primary key, {row[1:0], col[1:0]}
- cmd_dual  in  1  also close the second key (ghosting stimulus)
- cmd_key_b  in  4  second key, used only when cmd_dual=1
- cmd_hold  in  HOLD_W  stable-closed duration in cycles; 0 treated as 1
- abort  in  1  force early release
- row  in  4  row lines from scanner, active-low
- col  out  4  column lines to scanner, active-low (1 = pulled up)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, contact=0, all latched keys cleared, LFSR=LFSR_SEED, counter=0.
  - Outputs: col=4'b1111, cmd_ready=1, busy=0, done=0.
  - Takes effect immediately on assertion, including mid-press.
- Column mapping is combinational from row and registered state, like a real switch:
  - col[c] = 0 iff contact=1 and some latched key (r,c) has row[r]=0.
  - Second key contributes only when dual latched.
  - Both keys share the single contact bit.
  - Several rows low at once is legal; each is evaluated independently.
- Accept: on an edge with cmd_valid && cmd_ready, latch cmd_key, cmd_dual, cmd_key_b and max(cmd_hold,1). The next state is PRESS_BOUNCE, or HOLD if BOUNCE_CYCLES=0.
- FSM states: IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE.
  - PRESS_BOUNCE:
    - Lasts exactly BOUNCE_CYCLES cycles.
    - contact = LFSR[0], forced to 1 in the last cycle.
    - LFSR is 8-bit Fibonacci (x^8+x^6+x^5+x^4+1) and advances every bounce cycle only.
  - HOLD: contact=1 for exactly the latched hold cycles.
  - RELEASE_BOUNCE:
    - Lasts exactly BOUNCE_CYCLES cycles.
    - contact = LFSR[0], forced to 0 in the last cycle.
  - After RELEASE_BOUNCE (or HOLD if BOUNCE_CYCLES=0), go to IDLE; done=1 for that first IDLE cycle only.
- Counter: one down-counter, width max(HOLD_W, clog2(BOUNCE_CYCLES+1)). Loaded on each state entry; transition when it reaches the terminal count. No wrap beyond the load value.
- abort:
  - In PRESS_BOUNCE or HOLD: next state RELEASE_BOUNCE, counter reloaded, contact follows the release rules.
  - In RELEASE_BOUNCE or IDLE: ignored.
  - abort together with accept in IDLE: the command is accepted and abort is ignored.
- cmd_ready=0 whenever busy; commands offered while busy are held off, not dropped (standard valid/ready).
- The LFSR is never reseeded except by reset, so the bounce sequence is deterministic per reset.

Decomposition:
- keypad_pkg:
  - typedef emu_state_t (the four states).
  - key-code field positions.
  - LFSR tap constant.
  - Shared ROW_ACTIVE/COL_IDLE constants (4'b1111 idle levels), also used by the scanner.
- One sub-module: bounce_lfsr (8-bit, enable, seed parameter, async active-high reset). The FSM, counter and column mapping stay in keypad_emulator.

Test Plan:
- Reset, then row=4'b1110 with no command: col stays 4'b1111, cmd_ready=1, busy=0.
- BOUNCE_CYCLES=0, key 4'b0010 (row0, col2), hold 5, row=4'b1110:
  - col=4'b1011 for exactly 5 cycles after accept, then 4'b1111.
  - done pulses once; with row=4'b1101, col stays 4'b1111 throughout.
- BOUNCE_CYCLES=8, key 4'b1101 (row3, col1), hold 20, row=4'b0111:
  - col[1] toggles per the LFSR sequence from seed A5 for 8 cycles.
  - Then low for 20 cycles, then 8 bounce cycles ending high.
  - done fires at cycle 36 after accept.
- Dual press keys 0x0 and 0x1, row=4'b1110, BOUNCE_CYCLES=0: col=4'b1100 during hold, which is the ghost stimulus the scanner must reject.
- abort in HOLD cycle 3 of hold 100: release bounce starts next cycle, done after BOUNCE_CYCLES more cycles. A second command held on cmd_valid is accepted only on the cycle after done.
- rst asserted mid-HOLD: col=4'b1111 and busy=0 immediately (asynchronously). After release, a fresh command reproduces the seed-A5 bounce sequence.

Source files
------------

// File: rtl/keypad_emulator_pkg.sv
// Shared types and constants for the 4x4 keypad emulator and its scanner counterpart.
package keypad_pkg;

    typedef enum logic [1:0] {
        S_IDLE           = 2'd0,
        S_PRESS_BOUNCE   = 2'd1,
        S_HOLD           = 2'd2,
        S_RELEASE_BOUNCE = 2'd3
    } emu_state_t;

    // Key code layout: {row[1:0], col[1:0]}
    localparam int KEY_ROW_MSB = 3;
    localparam int KEY_ROW_LSB = 2;
    localparam int KEY_COL_MSB = 1;
    localparam int KEY_COL_LSB = 0;

    // x^8 + x^6 + x^5 + x^4 + 1, shift-left Fibonacci form: taps on bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Idle (pulled-up / undriven) levels of the active-low row and column lines
    localparam logic [3:0] ROW_ACTIVE = 4'b1111;
    localparam logic [3:0] COL_IDLE   = 4'b1111;

    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[KEY_ROW_MSB:KEY_ROW_LSB];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[KEY_COL_MSB:KEY_COL_LSB];
    endfunction

endpackage

// File: rtl/keypad_emulator_bounce_lfsr.sv
// 8-bit Fibonacci LFSR that supplies the pseudo-random contact bounce bit.
module bounce_lfsr
    import keypad_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_bit
);

    logic [7:0] r_lfsr;
    logic       w_feedback;

    assign w_feedback = ^(r_lfsr & LFSR_TAPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[6:0], w_feedback};
        end
    end

    assign o_bit = r_lfsr[0];

endmodule

// File: rtl/keypad_emulator.sv
// Far end of a 4x4 row-drive/column-sense keypad: closes emulated key contacts
// with pseudo-random bounce on press and release, driven by a valid/ready command.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int         BOUNCE_CYCLES = 64,
    parameter int         HOLD_W        = 16,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic              cmd_dual,
    input  logic [3:0]        cmd_key_b,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              abort,
    input  logic [3:0]        row,
    output logic [3:0]        col,
    output logic              busy,
    output logic              done
);

    localparam int BOUNCE_W = (BOUNCE_CYCLES > 0) ? $clog2(BOUNCE_CYCLES + 1) : 1;
    localparam int CNT_W    = (HOLD_W > BOUNCE_W) ? HOLD_W : BOUNCE_W;
    localparam logic [CNT_W-1:0] BOUNCE_LOAD =
        CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);

    emu_state_t        r_state;
    emu_state_t        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [3:0]        r_key_a;
    logic [3:0]        r_key_b;
    logic              r_dual;
    logic [HOLD_W-1:0] r_hold_m1;
    logic              r_done;
    logic              w_done_next;

    logic              w_accept;
    logic              w_last;
    logic              w_contact;
    logic              w_lfsr_en;
    logic              w_lfsr_bit;
    logic [HOLD_W-1:0] w_hold_m1;
    logic [3:0]        w_pull;

    // A zero hold request is stretched to one cycle
    assign w_hold_m1 = (cmd_hold == '0) ? '0 : cmd_hold - 1'b1;
    assign w_last    = (r_cnt == '0);

    bounce_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_lfsr_en),
        .o_bit (w_lfsr_bit)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        w_accept     = 1'b0;
        w_contact    = 1'b0;
        w_lfsr_en    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (BOUNCE_CYCLES == 0) begin
                        w_state_next = S_HOLD;
                        w_cnt_next   = CNT_W'(w_hold_m1);
                    end else begin
                        w_state_next = S_PRESS_BOUNCE;
                        w_cnt_next   = BOUNCE_LOAD;
                    end
                end
            end
            S_PRESS_BOUNCE: begin
                w_contact = w_last ? 1'b1 : w_lfsr_bit;
                w_lfsr_en = 1'b1;
                if (abort) begin
                    w_state_next = S_RELEASE_BOUNCE;
                    w_cnt_next   = BOUNCE_LOAD;
                end else if (w_last) begin
                    w_state_next = S_HOLD;
                    w_cnt_next   = CNT_W'(r_hold_m1);
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_HOLD: begin
                w_contact = 1'b1;
                if (abort || w_last) begin
                    // Without bounce there is no release phase to pass through
                    if (BOUNCE_CYCLES == 0) begin
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = S_RELEASE_BOUNCE;
                        w_cnt_next   = BOUNCE_LOAD;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_RELEASE_BOUNCE: begin
                w_contact = w_last ? 1'b0 : w_lfsr_bit;
                w_lfsr_en = 1'b1;
                if (w_last) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_key_a   <= '0;
            r_key_b   <= '0;
            r_dual    <= 1'b0;
            r_hold_m1 <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
            if (w_accept) begin
                r_key_a   <= cmd_key;
                r_key_b   <= cmd_key_b;
                r_dual    <= cmd_dual;
                r_hold_m1 <= w_hold_m1;
            end
        end
    end

    // Switch model: a closed key shorts its row to its column, so a column
    // follows any low row that has a closed key on it.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            logic w_hit_a;
            logic w_hit_b;
            assign w_hit_a    = (key_col(r_key_a) == 2'(gi)) && !row[key_row(r_key_a)];
            assign w_hit_b    = r_dual && (key_col(r_key_b) == 2'(gi)) && !row[key_row(r_key_b)];
            assign w_pull[gi] = w_contact && (w_hit_a || w_hit_b);
        end
    endgenerate

    assign col       = COL_IDLE & ~w_pull;
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench: one emulator without bounce (table + hand sequences) and one
// with 8-cycle bounce checked every cycle against a command-timeline reference model.
module tb_keypad_emulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- instance without bounce ----------------
    logic        v0 = 1'b0, d0 = 1'b0, a0 = 1'b0;
    logic [3:0]  k0 = '0, kb0 = '0, row0 = 4'b1111;
    logic [15:0] h0 = '0;
    logic        rdy0, busy0, done0;
    logic [3:0]  col0;

    keypad_emulator #(
        .BOUNCE_CYCLES (0),
        .HOLD_W        (16),
        .LFSR_SEED     (8'hA5)
    ) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (v0),
        .cmd_ready (rdy0),
        .cmd_key   (k0),
        .cmd_dual  (d0),
        .cmd_key_b (kb0),
        .cmd_hold  (h0),
        .abort     (a0),
        .row       (row0),
        .col       (col0),
        .busy      (busy0),
        .done      (done0)
    );

    // ---------------- instance with 8-cycle bounce ----------------
    localparam int MB = 8;
    logic        v8 = 1'b0, d8 = 1'b0, a8 = 1'b0;
    logic [3:0]  k8 = '0, kb8 = '0, row8 = 4'b1111;
    logic [15:0] h8 = '0;
    logic        rdy8, busy8, done8;
    logic [3:0]  col8;

    keypad_emulator #(
        .BOUNCE_CYCLES (MB),
        .HOLD_W        (16),
        .LFSR_SEED     (8'hA5)
    ) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (v8),
        .cmd_ready (rdy8),
        .cmd_key   (k8),
        .cmd_dual  (d8),
        .cmd_key_b (kb8),
        .cmd_hold  (h8),
        .abort     (a8),
        .row       (row8),
        .col       (col8),
        .busy      (busy8),
        .done      (done8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
        end
    endtask

    // Column levels from the switch rules: a closed key pulls its column low when its row is low
    function automatic logic [3:0] exp_col(input logic contact, input logic [3:0] r,
                                           input logic [3:0] ka, input logic [3:0] kb,
                                           input logic dual);
        logic [3:0] c;
        c = 4'b1111;
        if (contact) begin
            if (!r[ka[3:2]]) c[ka[1:0]] = 1'b0;
            if (dual && !r[kb[3:2]]) c[kb[1:0]] = 1'b0;
        end
        return c;
    endfunction

    // ---------------- reference model for the bounce instance ----------------
    // Each accepted command becomes a timeline of per-cycle contact steps.
    localparam logic [1:0] C_REL_LAST   = 2'd0;
    localparam logic [1:0] C_PRESS_LAST = 2'd1;
    localparam logic [1:0] C_BOUNCE     = 2'd2;
    localparam logic [1:0] C_HOLD       = 2'd3;

    typedef struct packed {
        logic       abortable;
        logic [1:0] code;
    } step_t;

    step_t      m_q[$];
    logic [7:0] m_lfsr;
    logic       m_done;
    logic [3:0] m_ka, m_kb;
    logic       m_dual;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic m_reset8();
        m_q.delete();
        m_lfsr = 8'hA5;
        m_done = 1'b0;
        m_ka   = '0;
        m_kb   = '0;
        m_dual = 1'b0;
    endtask

    // Called just after a negedge with inputs applied; checks, advances the model, waits a cycle
    task automatic cyc8(output logic o_done, output logic o_busy);
        logic  busy_m, contact_m;
        int    hold_n;
        step_t h;
        #1;
        busy_m    = (m_q.size() != 0);
        contact_m = 1'b0;
        if (busy_m) begin
            case (m_q[0].code)
                C_REL_LAST: contact_m = 1'b0;
                C_BOUNCE:   contact_m = m_lfsr[0];
                default:    contact_m = 1'b1;
            endcase
        end
        chk("col8", {28'd0, col8}, {28'd0, exp_col(contact_m, row8, m_ka, m_kb, m_dual)});
        chk("busy8", {31'd0, busy8}, {31'd0, busy_m});
        chk("ready8", {31'd0, rdy8}, {31'd0, !busy_m});
        chk("done8", {31'd0, done8}, {31'd0, m_done});
        o_done = done8;
        o_busy = busy8;
        if (!busy_m) begin
            m_done = 1'b0;
            if (v8) begin
                m_ka   = k8;
                m_kb   = kb8;
                m_dual = d8;
                hold_n = (h8 == 0) ? 1 : int'(h8);
                for (int i = 0; i < MB; i++) m_q.push_back({1'b1, (i == MB - 1) ? C_PRESS_LAST : C_BOUNCE});
                for (int i = 0; i < hold_n; i++) m_q.push_back({1'b1, C_HOLD});
                for (int i = 0; i < MB; i++) m_q.push_back({1'b0, (i == MB - 1) ? C_REL_LAST : C_BOUNCE});
                $display("txn dut8 key=%h key_b=%h dual=%0d hold=%0d t=%0t", k8, kb8, d8, hold_n, $time);
            end
        end else begin
            h = m_q.pop_front();
            if (h.code != C_HOLD) m_lfsr = lfsr_step(m_lfsr);
            if (a8 && h.abortable) begin
                while (m_q.size() != 0 && m_q[0].abortable) void'(m_q.pop_front());
            end
            m_done = (m_q.size() == 0);
        end
        @(negedge clk);
    endtask

    // Key D (row3,col1), hold 20, row3 driven: done expected 36 cycles after accept
    task automatic run_basic8(input string nm);
        logic dn, bz;
        int   done_at;
        row8 = 4'b0111; k8 = 4'hD; kb8 = 4'h0; d8 = 1'b0; h8 = 16'd20; a8 = 1'b0; v8 = 1'b1;
        cyc8(dn, bz);
        v8 = 1'b0;
        done_at = -1;
        for (int k = 0; k < 45; k++) begin
            cyc8(dn, bz);
            if (dn && done_at < 0) done_at = k;
        end
        chk(nm, done_at, 36);
    endtask

    // ---------------- helpers for the no-bounce instance ----------------
    task automatic accept0(input logic [3:0] k, input logic [3:0] kb, input logic d, input logic [15:0] h);
        k0 = k; kb0 = kb; d0 = d; h0 = h; v0 = 1'b1;
        #1;
        chk("accept0_ready", {31'd0, rdy0}, 32'd1);
        @(negedge clk);
        v0 = 1'b0;
        $display("txn dut0 key=%h key_b=%h dual=%0d hold=%0d t=%0t", k, kb, d, h, $time);
    endtask

    task automatic wait_done0(output int at);
        at = -1;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (done0) begin
                at = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [3:0] key;
        logic [3:0] kb;
        logic       dual;
        logic [3:0] row;
        logic [3:0] col;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic dn, bz;
        int   at, done_at, busy20;

        tbl[0] = '{4'h2, 4'h0, 1'b0, 4'b1110, 4'b1011};
        tbl[1] = '{4'h2, 4'h0, 1'b0, 4'b1101, 4'b1111};
        tbl[2] = '{4'h0, 4'h1, 1'b1, 4'b1110, 4'b1100};
        tbl[3] = '{4'h6, 4'hB, 1'b1, 4'b1001, 4'b0011};
        tbl[4] = '{4'h6, 4'hB, 1'b0, 4'b1001, 4'b1011};
        tbl[5] = '{4'hF, 4'h0, 1'b0, 4'b0111, 4'b0111};
        tbl[6] = '{4'hF, 4'h0, 1'b1, 4'b0110, 4'b0110};
        tbl[7] = '{4'h5, 4'h0, 1'b0, 4'b1111, 4'b1111};

        m_reset8();
        repeat (2) @(negedge clk);
        row0 = 4'b1110; row8 = 4'b1110;
        #1;
        chk("rst_col0", {28'd0, col0}, 32'hF);
        chk("rst_ready0", {31'd0, rdy0}, 32'd1);
        chk("rst_busy0", {31'd0, busy0}, 32'd0);
        chk("rst_done8", {31'd0, done8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("idle_col0", {28'd0, col0}, 32'hF);
            chk("idle_busy0", {31'd0, busy0}, 32'd0);
            @(negedge clk);
            cyc8(dn, bz);
        end

        // No bounce: contact closed for exactly the hold time
        row0 = 4'b1110;
        accept0(4'h2, 4'h0, 1'b0, 16'd5);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("b0_col_row0", {28'd0, col0}, (k < 5) ? 32'hB : 32'hF);
            chk("b0_done_row0", {31'd0, done0}, (k == 5) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        row0 = 4'b1101;
        accept0(4'h2, 4'h0, 1'b0, 16'd5);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("b0_col_row1", {28'd0, col0}, 32'hF);
            chk("b0_done_row1", {31'd0, done0}, (k == 5) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // Zero hold is stretched to one cycle
        row0 = 4'b1110;
        accept0(4'h2, 4'h0, 1'b0, 16'd0);
        #1;
        chk("hold0_col", {28'd0, col0}, 32'hB);
        @(negedge clk);
        #1;
        chk("hold0_done", {31'd0, done0}, 32'd1);
        @(negedge clk);

        // Column mapping table, sampled in the first hold cycle
        for (int i = 0; i < 8; i++) begin
            row0 = tbl[i].row;
            accept0(tbl[i].key, tbl[i].kb, tbl[i].dual, 16'd3);
            #1;
            chk($sformatf("tbl%0d_col", i), {28'd0, col0}, {28'd0, tbl[i].col});
            wait_done0(at);
            chk($sformatf("tbl%0d_done_at", i), at, 3);
            @(negedge clk);
        end

        // Bounce instance: seed sequence, hold, release
        run_basic8("basic8_done_at");

        // Abort in the third hold cycle, second command waiting on valid
        row8 = 4'b0111; k8 = 4'hD; d8 = 1'b0; h8 = 16'd100; a8 = 1'b0; v8 = 1'b1;
        cyc8(dn, bz);
        k8 = 4'h3; h8 = 16'd2;
        done_at = -1;
        busy20  = -1;
        for (int k = 0; k < 40; k++) begin
            a8 = (k == 10);
            if (k == 20) v8 = 1'b0;
            cyc8(dn, bz);
            if (dn && done_at < 0) done_at = k;
            if (k == 20) busy20 = int'(bz);
        end
        chk("abort_done_at", done_at, 19);
        chk("abort_second_busy", busy20, 1);

        // Asynchronous reset in the middle of a hold
        row8 = 4'b0111; k8 = 4'hD; d8 = 1'b0; h8 = 16'd50; v8 = 1'b1;
        cyc8(dn, bz);
        v8 = 1'b0;
        for (int k = 0; k < 12; k++) cyc8(dn, bz);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_col8", {28'd0, col8}, 32'hF);
        chk("arst_busy8", {31'd0, busy8}, 32'd0);
        chk("arst_ready8", {31'd0, rdy8}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset8();
        run_basic8("post_rst_done_at");

        // Randomised traffic against the reference model
        for (int n = 0; n < 700; n++) begin
            row8 = 4'($urandom_range(0, 15));
            v8   = ($urandom_range(0, 3) == 0);
            k8   = 4'($urandom_range(0, 15));
            kb8  = 4'($urandom_range(0, 15));
            d8   = 1'($urandom_range(0, 1));
            h8   = 16'($urandom_range(0, 6));
            a8   = ($urandom_range(0, 15) == 0);
            cyc8(dn, bz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
